// File: rtl/rsa_frame_rx_if.sv
// Byte-stream / operand-handoff bundle between the UART side, rsa_frame_rx and mon_exp.
interface rsa_frame_rx_if #(
    parameter int unsigned BITLEN     = 64,
    parameter int unsigned LOG_BITLEN = 6,
    parameter int unsigned NUM_OPS    = 3,
    parameter int unsigned ABITS      = 8
);
    logic                        rx_valid;
    logic [7:0]                  rx_byte;
    logic                        core_busy;
    logic [NUM_OPS*BITLEN-1:0]   ops;
    logic                        ops_valid;
    logic [LOG_BITLEN-1:0]       e_idx;
    logic                        e_zero;
    logic [ABITS-1:0]            wr_addr;
    logic [BITLEN-1:0]           wr_data;
    logic                        wr_en;
    logic                        frame_err;
    logic [1:0]                  err_code;
    logic                        busy;

    // Host/environment side: drives bytes and core status, observes results
    modport master (
        output rx_valid, rx_byte, core_busy,
        input  ops, ops_valid, e_idx, e_zero, wr_addr, wr_data, wr_en,
               frame_err, err_code, busy
    );

    // Deserializer side
    modport slave (
        input  rx_valid, rx_byte, core_busy,
        output ops, ops_valid, e_idx, e_zero, wr_addr, wr_data, wr_en,
               frame_err, err_code, busy
    );
endinterface

// File: rtl/rsa_frame_rx.sv
// Framed operand deserializer: header + NUM_OPS operands + XOR checksum,
// exponent MSB scan, BRAM write of op0, and handoff to mon_exp.
module rsa_frame_rx #(
    parameter int unsigned BITLEN     = 64,
    parameter int unsigned LOG_BITLEN = 6,
    parameter int unsigned NUM_OPS    = 3,
    parameter int unsigned EXP_SEL    = 1,
    parameter int unsigned ABITS      = 8,
    parameter int unsigned WR_ADDR    = 0,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT    = 120000
) (
    input  logic            clk,
    input  logic            rst,
    rsa_frame_rx_if.slave   bus
);

    localparam int unsigned TOTAL = NUM_OPS * BITLEN;
    localparam int unsigned BPO   = BITLEN / 8;
    localparam int unsigned OPW   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int unsigned BCW   = (BPO > 1) ? $clog2(BPO) : 1;
    localparam int unsigned PW    = $clog2(TOTAL);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_SCAN    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [OPW-1:0]        op_cnt_q, op_cnt_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [TOTAL-1:0]      shadow_q, shadow_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [LOG_BITLEN-1:0] idx_q, idx_d;
    logic [TOTAL-1:0]      ops_q, ops_d;
    logic [LOG_BITLEN-1:0] e_idx_q, e_idx_d;
    logic                  e_zero_q, e_zero_d;
    logic [ABITS-1:0]      wr_addr_q, wr_addr_d;
    logic [BITLEN-1:0]     wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  ops_valid_q, ops_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  busy_q, busy_d;

    logic [PW-1:0]         byte_pos;
    logic [BITLEN-1:0]     exp_op;

    assign exp_op = ops_q[EXP_SEL*BITLEN +: BITLEN];

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        op_cnt_d    = op_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        csum_d      = csum_q;
        shadow_d    = shadow_q;
        tmo_d       = tmo_q;
        idx_d       = idx_q;
        ops_d       = ops_q;
        e_idx_d     = e_idx_q;
        e_zero_d    = e_zero_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        ops_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        // Operands arrive MSB byte first, op0 first; place each byte directly.
        byte_pos = PW'(32'(op_cnt_q) * BITLEN + (BPO - 1 - 32'(byte_cnt_q)) * 8);

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_byte == HDR_BYTE) begin
                    op_cnt_d   = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                    tmo_d      = '0;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (bus.rx_valid) begin
                    shadow_d[byte_pos +: 8] = bus.rx_byte;
                    csum_d = csum_q ^ bus.rx_byte;
                    if (byte_cnt_q == BCW'(BPO - 1)) begin
                        byte_cnt_d = '0;
                        if (op_cnt_q == OPW'(NUM_OPS - 1)) begin
                            state_d = S_CHECK;
                        end else begin
                            op_cnt_d = op_cnt_q + OPW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            S_CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == csum_q) begin
                        ops_d   = shadow_q;
                        idx_d   = LOG_BITLEN'(BITLEN - 1);
                        state_d = S_SCAN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b01;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_SCAN: begin
                if (exp_op[idx_q]) begin
                    e_idx_d  = idx_q;
                    e_zero_d = 1'b0;
                    state_d  = S_WRITE;
                end else if (idx_q == '0) begin
                    e_idx_d  = '0;
                    e_zero_d = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    idx_d = idx_q - LOG_BITLEN'(1);
                end
            end
            S_WRITE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ABITS'(WR_ADDR);
                wr_data_d = ops_q[BITLEN-1:0];
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.core_busy) begin
                    ops_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout while a frame is being received
        if (state_q == S_PAYLOAD || state_q == S_CHECK) begin
            if (bus.rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                frame_err_d = 1'b1;
                err_code_d  = 2'b10;
                state_d     = S_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        // Bytes arriving after the frame is accepted are dropped as overruns
        if (bus.rx_valid && (state_q == S_SCAN || state_q == S_WRITE || state_q == S_WAIT)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b11;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_cnt_q    <= '0;
            byte_cnt_q  <= '0;
            csum_q      <= '0;
            shadow_q    <= '0;
            tmo_q       <= '0;
            idx_q       <= '0;
            ops_q       <= '0;
            e_idx_q     <= '0;
            e_zero_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            ops_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_cnt_q    <= op_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            shadow_q    <= shadow_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            ops_q       <= ops_d;
            e_idx_q     <= e_idx_d;
            e_zero_q    <= e_zero_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            ops_valid_q <= ops_valid_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ops       = ops_q;
    assign bus.ops_valid = ops_valid_q;
    assign bus.e_idx     = e_idx_q;
    assign bus.e_zero    = e_zero_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rsa_frame_rx.sv
// Directed bench for rsa_frame_rx: good/bad frames, timeout, hold-off, scan bounds, reset.
module tb_rsa_frame_rx;

    localparam int unsigned TMO = 300;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rsa_frame_rx_if #(.BITLEN(64), .LOG_BITLEN(6), .NUM_OPS(3), .ABITS(8)) bus ();

    rsa_frame_rx #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Observation results from watch()
    int          wr_k, ov_k, err_k, wr_cnt, err_cnt;
    logic [63:0] cap_wr_data;
    logic [7:0]  cap_wr_addr;

    localparam logic [63:0] OP0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] OP1 = 64'h0000000000010001;
    localparam logic [63:0] OP2 = 64'hFFFFFFFFFFFFFFC5;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_ops(input logic [63:0] o0, input logic [63:0] o1,
                            input logic [63:0] o2, input int nbytes);
        logic [191:0] all;
        int n;
        all = {o2, o1, o0};
        n = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 7; j >= 0; j--) begin
                if (n < nbytes) send_byte(all[k*64 + j*8 +: 8]);
                n++;
            end
        end
    endtask

    task automatic send_frame(input logic [63:0] o0, input logic [63:0] o1,
                              input logic [63:0] o2, input logic [7:0] c);
        send_byte(8'hA5);
        send_ops(o0, o1, o2, 24);
        send_byte(c);
    endtask

    // Observe outputs each negedge, k counted in cycles after the last sampled byte
    task automatic watch(input int k0, input int budget);
        wr_k = -1; ov_k = -1; err_k = -1; wr_cnt = 0; err_cnt = 0;
        for (int k = k0; k <= k0 + budget; k++) begin
            if (bus.wr_en) begin
                wr_cnt++;
                if (wr_k < 0) wr_k = k;
                cap_wr_data = bus.wr_data;
                cap_wr_addr = bus.wr_addr;
            end
            if (bus.frame_err) begin
                err_cnt++;
                if (err_k < 0) err_k = k;
            end
            if (bus.ops_valid) begin
                ov_k = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int b_wr_cnt, b_wr_k, b_ov_cnt, b_err_k;
        rst = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.core_busy = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ops", bus.ops, 192'h0);
        chk("rst_ctrl", 192'({bus.ops_valid, bus.wr_en, bus.frame_err, bus.busy, bus.e_zero}), 192'h0);
        chk("rst_err_code", 192'(bus.err_code), 192'h0);
        chk("rst_e_idx", 192'(bus.e_idx), 192'h0);
        rst = 1'b0;
        @(negedge clk);

        // Good frame with default operands, checksum 3A
        send_frame(OP0, OP1, OP2, 8'h3A);
        watch(0, 80);
        chk_int("f1_wr_k", wr_k, 49);
        chk_int("f1_ov_k", ov_k, 50);
        chk_int("f1_wr_cnt", wr_cnt, 1);
        chk_int("f1_err_cnt", err_cnt, 0);
        chk("f1_wr_data", 192'(cap_wr_data), 192'(OP0));
        chk("f1_wr_addr", 192'(cap_wr_addr), 192'h0);
        chk("f1_e_idx", 192'(bus.e_idx), 192'd16);
        chk("f1_e_zero", 192'(bus.e_zero), 192'h0);
        chk("f1_ops", bus.ops, {OP2, OP1, OP0});
        @(negedge clk);
        chk("f1_idle", 192'({bus.busy, bus.ops_valid}), 192'h0);

        // Inverted checksum: error, nothing handed off, ops retained
        send_frame(64'h1111111111111111, 64'h2, OP2, 8'hC5);
        chk("bad_err", 192'(bus.frame_err), 192'h1);
        chk("bad_code", 192'(bus.err_code), 192'h1);
        watch(0, 80);
        chk_int("bad_wr_cnt", wr_cnt, 0);
        chk_int("bad_ov_k", ov_k, -1);
        chk_int("bad_err_cnt", err_cnt, 1);
        chk("bad_ops", bus.ops, {OP2, OP1, OP0});

        // Timeout after 10 payload bytes
        send_byte(8'hA5);
        send_ops(OP0, OP1, OP2, 10);
        watch(0, TMO + 20);
        chk_int("tmo_err_k", err_k, TMO);
        chk_int("tmo_err_cnt", err_cnt, 1);
        chk("tmo_code", 192'(bus.err_code), 192'h2);
        chk("tmo_busy", 192'(bus.busy), 192'h0);

        // Zero exponent: full-length scan
        send_frame(OP0, 64'h0, OP2, 8'h3A);
        watch(0, 100);
        chk_int("z_wr_k", wr_k, 65);
        chk_int("z_ov_k", ov_k, 66);
        chk("z_e_zero", 192'(bus.e_zero), 192'h1);
        chk("z_e_idx", 192'(bus.e_idx), 192'h0);
        chk("z_ops", bus.ops, {OP2, 64'h0, OP0});
        @(negedge clk);

        // Top-bit exponent: single-cycle scan
        send_frame(OP0, 64'h8000000000000000, OP2, 8'hBA);
        watch(0, 20);
        chk_int("t_ov_k", ov_k, 3);
        chk("t_e_idx", 192'(bus.e_idx), 192'd63);
        chk("t_e_zero", 192'(bus.e_zero), 192'h0);
        @(negedge clk);

        // Core busy hold-off with an overrun byte during the wait
        bus.core_busy = 1'b1;
        send_frame(OP0, OP1, OP2, 8'h3A);
        b_wr_cnt = 0; b_wr_k = -1; b_ov_cnt = 0; b_err_k = -1;
        for (int k = 0; k < 500; k++) begin
            if (bus.wr_en) begin
                b_wr_cnt++;
                if (b_wr_k < 0) b_wr_k = k;
            end
            if (bus.ops_valid) b_ov_cnt++;
            if (bus.frame_err && b_err_k < 0) b_err_k = k;
            bus.rx_valid = (k == 100);
            bus.rx_byte  = 8'h11;
            @(negedge clk);
        end
        bus.rx_valid  = 1'b0;
        chk_int("cb_wr_k", b_wr_k, 49);
        chk_int("cb_wr_cnt", b_wr_cnt, 1);
        chk_int("cb_no_ov", b_ov_cnt, 0);
        chk_int("cb_err_k", b_err_k, 101);
        chk("cb_code", 192'(bus.err_code), 192'h3);
        bus.core_busy = 1'b0;
        watch(500, 10);
        chk_int("cb_ov_k", ov_k, 501);
        chk("cb_e_idx", 192'(bus.e_idx), 192'd16);
        @(negedge clk);

        // Reset during payload byte 12
        send_byte(8'hA5);
        send_ops(64'hDEADBEEFCAFEF00D, OP1, OP2, 11);
        rst = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        chk("mr_ops", bus.ops, 192'h0);
        chk("mr_e_idx", 192'(bus.e_idx), 192'h0);
        chk("mr_ctrl", 192'({bus.busy, bus.err_code, bus.frame_err, bus.wr_en, bus.ops_valid}), 192'h0);
        for (int n = 0; n < 25; n++) send_byte(8'h3C);
        chk("mr_ignored", 192'({bus.busy, bus.frame_err}), 192'h0);

        // Normal frame after reset
        send_frame(OP0, OP1, OP2, 8'h3A);
        watch(0, 80);
        chk_int("pr_ov_k", ov_k, 50);
        chk("pr_ops", bus.ops, {OP2, OP1, OP0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
